uart_cmd_responder: RTL and testbench
=====================================

# uart_cmd_responder

Far-end command responder for the UART link: consumes received bytes, parses 2–3 byte read/write command frames, and operates on a local 16 x 8 register file. Each frame gets exactly one response byte, which the block passes to the UART transmitter through its start/done handshake. It sits between the UART receiver (byte strobe side) and the UART transmitter (xmit/done side) and gives a host a register-access channel over the serial line.

## Interface
Parameters:
- TIMEOUT_CYCLES, 100000: inter-byte timeout within a frame, in sys_clk cycles. Range 2..2^20-1.

Ports:
- sys_clk  input  1  clock
- sys_rst_l  input  1  reset; asynchronous, active-low
- rx_dataH  input  8  received byte; valid only when rx_strobeH is high
- rx_strobeH  input  1  one-cycle strobe, one per received byte
- tx_startH  output  1  one-cycle request to the transmitter; tx_dataH is valid in the same cycle
- tx_dataH  output  8  response byte; held stable from tx_startH until the response completes
- tx_doneH  input  1  transmitter idle level (high = idle/finished, low = sending)
- reg_fileH  output  128  register file, flat; reg n = bits [8n+7:8n]
- busyH  output  1  high whenever state != IDLE
- frame_errH  output  1  one-cycle pulse on a timeout abort or on a byte dropped while responding

## Operation
Frame format:
- Write: 0x57 ('W'), ADDR, DATA.
- Read: 0x52 ('R'), ADDR.
- ADDR[3:0] selects the register. ADDR[7:4] must be 0.

Responses:
- Write OK: 0x4B.
- Read OK: register value.
- Bad opcode or ADDR[7:4] != 0: 0x3F.

States, reset to IDLE:
- IDLE: on strobe, capture opcode.
  - 0x57 or 0x52 -> GET_ADDR.
  - Any other byte: load tx_dataH=0x3F -> TX_START.
- GET_ADDR: on strobe, capture addr.
  - Read, addr valid: tx_dataH=reg[addr] -> TX_START.
  - Read, addr invalid: tx_dataH=0x3F -> TX_START.
  - Write: -> GET_DATA.
- GET_DATA: on strobe.
  - addr valid: reg[addr]<=rx_dataH and tx_dataH=0x4B, both at the same edge -> TX_START.
  - addr invalid: no write, tx_dataH=0x3F -> TX_START.
- TX_START: tx_startH=1 for exactly one cycle, and only in a cycle where tx_doneH=1. If tx_doneH=0, wait. Then -> TX_WAIT.
- TX_WAIT: ignore tx_doneH in the first cycle (guard cycle; the transmitter drops done one cycle after start). From the second cycle on, tx_doneH=1 -> IDLE.

Timeout:
- A 20-bit counter clears on every accepted strobe and on entry to GET_ADDR.
- It counts in GET_ADDR and GET_DATA.
- Reaching TIMEOUT_CYCLES-1: -> IDLE, frame_errH pulse, no register write, no response.

Other rules:
- Strobe in TX_START or TX_WAIT: the byte is dropped and frame_errH pulses. No state change.
- Strobe and timeout terminal count in the same cycle: the strobe wins, the byte is accepted and the counter clears.
- Reset mid-frame or mid-response: immediate IDLE, all registers 0, tx_startH 0. An in-flight response byte is abandoned.

Reset values: tx_startH 0, tx_dataH 0x00, reg_fileH 0, busyH 0, frame_errH 0.

## Timing
- All outputs are registered. Nothing is combinational from inputs.
- Last byte of a frame strobed in cycle N:
  - Register write visible N+1.
  - busyH already high.
  - tx_startH high in N+1 if tx_doneH=1 in N+1, else in the first later cycle with tx_doneH=1.
- Read: tx_dataH is the register value sampled at the ADDR strobe edge. A register cannot change in between, because the only write path is this FSM.
- Opcode error: strobe at N -> tx_startH at N+1 (0x3F).
- busyH falls in the cycle after tx_doneH is seen high in TX_WAIT (not the guard cycle).
- Minimum frame-to-frame spacing is the transmit duration. Bytes strobed before busyH falls are dropped.
- Timeout: Nth idle cycle after the last strobe, with N = TIMEOUT_CYCLES -> IDLE.

## Test plan
- Write: strobes 0x57, 0x03, 0xA5 -> reg[3]=0xA5 one cycle after the third strobe; one tx_startH with tx_dataH=0x4B; other registers 0.
- Read back: after the write above, 0x52, 0x03 -> tx_dataH=0xA5, single tx_startH pulse; busyH drops after tx_doneH low→high.
- Errors: opcode 0x11 -> 0x3F next cycle. Frame 0x57, 0x13, 0x77 -> 0x3F and no register changes.
- Timeout with TIMEOUT_CYCLES=8: 0x57 then no strobe -> frame_errH pulse 8 cycles later, no tx_startH, busyH 0. A following 0x52, 0x00 returns 0x00.
- Handshake/overrun: hold tx_doneH=0 when the response is ready -> tx_startH is delayed until tx_doneH=1. A strobe during TX_WAIT -> frame_errH pulse, byte ignored, response unaffected.
- Reset mid-frame: sys_rst_l low after 0x57, 0x05 -> all outputs at reset values immediately. After release, a full write to reg 5 works normally.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Far-end command responder for the UART link. Parses 'W' ADDR DATA and
//   'R' ADDR frames from the receiver byte strobe. It accesses a local
//   16 x 8 register file and returns one response byte per frame through the
//   transmitter start/done handshake.
// Ports:
//   sys_clk, sys_rst_l      clock, async active-low reset
//   rx_dataH, rx_strobeH    received byte + one-cycle strobe
//   tx_startH, tx_dataH     one-cycle transmit request + response byte
//   tx_doneH                transmitter idle level (high = idle)
//   reg_fileH               flat register file, reg n = [8n+7:8n]
//   busyH                   high while a frame or response is in progress
//   frame_errH              pulse on timeout abort or byte dropped while busy
module uart_cmd_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic         sys_clk,
    input  logic         sys_rst_l,
    input  logic [7:0]   rx_dataH,
    input  logic         rx_strobeH,
    output logic         tx_startH,
    output logic [7:0]   tx_dataH,
    input  logic         tx_doneH,
    output logic [127:0] reg_fileH,
    output logic         busyH,
    output logic         frame_errH
);
    localparam logic [7:0]  OP_W    = 8'h57;
    localparam logic [7:0]  OP_R    = 8'h52;
    localparam logic [7:0]  RSP_OK  = 8'h4B;
    localparam logic [7:0]  RSP_ERR = 8'h3F;
    localparam logic [19:0] CNT_TERM = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_TX_START, S_TX_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              is_write_q, is_write_d;
    logic [7:0]        addr_q, addr_d;
    logic [19:0]       cnt_q, cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic [15:0][7:0]  regs_q, regs_d;
    logic              busy_q, busy_d;
    logic              ferr_q, ferr_d;
    logic              guard_q;

    logic in_frame;
    logic cnt_term;

    assign in_frame = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
    // A strobe in the terminal cycle takes priority over the timeout.
    assign cnt_term = in_frame && !rx_strobeH && (cnt_q == CNT_TERM);

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            regs_q     <= '0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
            guard_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            ferr_q     <= ferr_d;
            // High in the first TX_WAIT cycle, while the transmitter is
            // still reacting to the start pulse.
            guard_q    <= (state_q == S_TX_START);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (rx_strobeH)
                    state_d = (rx_dataH == OP_W || rx_dataH == OP_R) ? S_GET_ADDR : S_TX_START;
            S_GET_ADDR:
                if (rx_strobeH)    state_d = is_write_q ? S_GET_DATA : S_TX_START;
                else if (cnt_term) state_d = S_IDLE;
            S_GET_DATA:
                if (rx_strobeH)    state_d = S_TX_START;
                else if (cnt_term) state_d = S_IDLE;
            S_TX_START:
                if (tx_start_q) state_d = S_TX_WAIT;
            S_TX_WAIT:
                if (!guard_q && tx_doneH) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values. tx_startH is registered, so the start
    // request is launched one edge early from the tx_doneH level seen in
    // the preceding cycle. done only falls after a start, so it is still
    // high in the pulse cycle.
    always_comb begin
        is_write_d = is_write_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        regs_d     = regs_q;
        ferr_d     = 1'b0;
        cnt_d      = (in_frame && !rx_strobeH) ? cnt_q + 20'd1 : '0;
        unique case (state_q)
            S_IDLE:
                if (rx_strobeH) begin
                    is_write_d = (rx_dataH == OP_W);
                    if (rx_dataH != OP_W && rx_dataH != OP_R) begin
                        tx_data_d  = RSP_ERR;
                        tx_start_d = tx_doneH;
                    end
                end
            S_GET_ADDR:
                if (rx_strobeH) begin
                    addr_d = rx_dataH;
                    if (!is_write_q) begin
                        tx_data_d  = (rx_dataH[7:4] == 4'h0) ? regs_q[rx_dataH[3:0]] : RSP_ERR;
                        tx_start_d = tx_doneH;
                    end
                end else if (cnt_term) begin
                    ferr_d = 1'b1;
                end
            S_GET_DATA:
                if (rx_strobeH) begin
                    if (addr_q[7:4] == 4'h0) begin
                        regs_d[addr_q[3:0]] = rx_dataH;
                        tx_data_d           = RSP_OK;
                    end else begin
                        tx_data_d = RSP_ERR;
                    end
                    tx_start_d = tx_doneH;
                end else if (cnt_term) begin
                    ferr_d = 1'b1;
                end
            S_TX_START: begin
                if (!tx_start_q && tx_doneH) tx_start_d = 1'b1;
                if (rx_strobeH) ferr_d = 1'b1;
            end
            S_TX_WAIT:
                if (rx_strobeH) ferr_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign tx_startH  = tx_start_q;
    assign tx_dataH   = tx_data_q;
    assign reg_fileH  = regs_q;
    assign busyH      = busy_q;
    assign frame_errH = ferr_q;
endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;
    localparam int TO = 8;

    logic         sys_clk = 1'b0;
    logic         sys_rst_l = 1'b0;
    logic [7:0]   rx_dataH = 8'h00;
    logic         rx_strobeH = 1'b0;
    logic         tx_startH;
    logic [7:0]   tx_dataH;
    logic         tx_doneH;
    logic [127:0] reg_fileH;
    logic         busyH;
    logic         frame_errH;

    uart_cmd_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l),
        .rx_dataH(rx_dataH), .rx_strobeH(rx_strobeH),
        .tx_startH(tx_startH), .tx_dataH(tx_dataH), .tx_doneH(tx_doneH),
        .reg_fileH(reg_fileH), .busyH(busyH), .frame_errH(frame_errH)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0, bad = 0;
    logic [7:0] exp_q[$];
    int exp_ferr = 0, obs_ferr = 0, starts = 0;
    logic [7:0] mreg [16];

    // Transmitter model: done drops the cycle after start, stays low xmit_len cycles.
    int   xmit_cnt = 0;
    int   xmit_len = 4;
    logic hold_done = 1'b0;
    assign tx_doneH = (xmit_cnt == 0) && !hold_done;
    always @(posedge sys_clk)
        if (tx_startH) xmit_cnt <= xmit_len;
        else if (xmit_cnt > 0) xmit_cnt <= xmit_cnt - 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++; bad++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    function automatic logic [127:0] flat();
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = mreg[i];
        return v;
    endfunction

    // Monitor / scoreboard
    always @(negedge sys_clk) if (sys_rst_l) begin
        if (frame_errH) obs_ferr++;
        if (tx_startH) begin
            starts++;
            chk("start_with_done", tx_doneH, 1'b1);
            if (exp_q.size() == 0) fail("unexpected_start");
            else chk("resp_byte", tx_dataH, exp_q.pop_front());
        end
    end

    // Tasks are entered and return just after a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_dataH = b; rx_strobeH = 1'b1;
        @(negedge sys_clk);
        rx_strobeH = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge sys_clk);
            if (!busyH && xmit_cnt == 0 && tx_doneH) ok = 1;
        end
        if (!ok) fail("idle_timeout");
        @(negedge sys_clk);
    endtask

    task automatic frame_write(input logic [7:0] a, input logic [7:0] d, input int gap);
        if (a[7:4] == 4'h0) begin mreg[a[3:0]] = d; exp_q.push_back(8'h4B); end
        else exp_q.push_back(8'h3F);
        send_byte(8'h57, gap);
        send_byte(a, gap);
        send_byte(d, 0);
    endtask

    task automatic frame_read(input logic [7:0] a, input int gap);
        exp_q.push_back(a[7:4] == 4'h0 ? mreg[a[3:0]] : 8'h3F);
        send_byte(8'h52, gap);
        send_byte(a, 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_txstart"}, tx_startH, 1'b0);
        chk({nm, "_txdata"}, tx_dataH, 8'h00);
        chk({nm, "_regs"}, reg_fileH, 128'h0);
        chk({nm, "_busy"}, busyH, 1'b0);
        chk({nm, "_ferr"}, frame_errH, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, s0;
        bit seen;
        logic [7:0] a, op;
        for (int i = 0; i < 16; i++) mreg[i] = 8'h00;

        repeat (3) @(negedge sys_clk);
        chk_reset_vals("reset");
        sys_rst_l = 1'b1;
        @(negedge sys_clk);

        // Write reg3 = A5: visible and start requested one cycle after last strobe
        frame_write(8'h03, 8'hA5, 0);
        chk("write_visible", reg_fileH, flat());
        chk("write_start_n1", tx_startH, 1'b1);
        wait_idle();

        // Read back
        frame_read(8'h03, 0);
        chk("read_start_n1", tx_startH, 1'b1);
        chk("read_busy", busyH, 1'b1);
        wait_idle();
        chk("read_busy_fall", busyH, 1'b0);

        // Bad opcode
        exp_q.push_back(8'h3F);
        send_byte(8'h11, 0);
        chk("badop_start_n1", tx_startH, 1'b1);
        chk("badop_data", tx_dataH, 8'h3F);
        wait_idle();

        // Bad address on a write: error response, no register change
        frame_write(8'h13, 8'h77, 0);
        wait_idle();
        chk("badaddr_regs", reg_fileH, flat());

        // Timeout after an opcode
        send_byte(8'h57, 0);
        k = 0;
        while (!frame_errH && k < 50) begin @(negedge sys_clk); k++; end
        exp_ferr++;
        chk("timeout_cycles", k, TO);
        chk("timeout_busy", busyH, 1'b0);
        chk("timeout_txstart", tx_startH, 1'b0);
        @(negedge sys_clk);
        frame_read(8'h00, 0);
        wait_idle();

        // Transmitter busy: start must wait for done
        hold_done = 1'b1;
        s0 = starts;
        frame_read(8'h03, 0);
        repeat (6) @(negedge sys_clk);
        chk("held_no_start", starts, s0);
        chk("held_busy", busyH, 1'b1);
        hold_done = 1'b0;
        wait_idle();
        chk("held_start_once", starts, s0 + 1);

        // Overrun: byte during TX_WAIT is dropped with frame_err
        xmit_len = 20;
        frame_read(8'h03, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (tx_startH) seen = 1;
            @(negedge sys_clk);
        end
        if (!seen) fail("overrun_start");
        @(negedge sys_clk);
        exp_ferr++;
        send_byte(8'h99, 0);
        wait_idle();
        xmit_len = 4;

        // Reset mid-frame
        send_byte(8'h57, 0);
        send_byte(8'h05, 0);
        sys_rst_l = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
        chk_reset_vals("midreset");
        repeat (2) @(negedge sys_clk);
        sys_rst_l = 1'b1;
        @(negedge sys_clk);
        frame_write(8'h05, 8'h3C, 0);
        chk("postreset_write", reg_fileH, flat());
        wait_idle();
        frame_read(8'h05, 1);
        wait_idle();

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            int kind, gap;
            kind = $urandom_range(0, 4);
            gap = $urandom_range(0, 3);
            xmit_len = $urandom_range(2, 6);
            case (kind)
                0: begin a = 8'($urandom_range(0, 15)); frame_write(a, 8'($urandom_range(0, 255)), gap); end
                1: begin a = 8'($urandom_range(0, 15)); frame_read(a, gap); end
                2: begin a = 8'($urandom_range(16, 255)); frame_write(a, 8'($urandom_range(0, 255)), gap); end
                3: begin a = 8'($urandom_range(16, 255)); frame_read(a, gap); end
                default: begin
                    op = 8'($urandom_range(0, 255));
                    while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
                    exp_q.push_back(8'h3F);
                    send_byte(op, 0);
                end
            endcase
            wait_idle();
            chk("rand_regs", reg_fileH, flat());
        end

        chk("ferr_count", obs_ferr, exp_ferr);
        chk("resp_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
